// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream-format constants for the boot loader.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: packs little-endian stream bytes into 32-bit words, word_valid on the 4th byte.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sh;
    logic [1:0]  cnt;

    assign word       = {data, sh};
    assign word_valid = strobe && cnt == 2'(BYTES_PER_WORD - 1);

    // shift bytes in from the top so the first byte ends up in [7:0]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sh  <= '0;
            cnt <= '0;
        end else if (strobe) begin
            sh  <= {data, sh[23:8]};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader writing a host byte stream into instruction memory while holding the core in reset.
// Optional checksum byte after the data is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHECK;
    logic [7:0] acc;
`else
    localparam state_t S_END = S_FLUSH;
`endif

    localparam logic END_READY = (S_END != S_FLUSH);

    state_t          state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] n_full;
    logic [ADDR_W:0] wcnt;
    logic            accept;
    logic            last_word;
    logic            do_reload;
    logic [31:0]     word;
    logic            word_valid;

    assign accept    = in_valid && in_ready;
    assign n_full    = {in_data, len[7:0]};
    assign last_word = 32'(wcnt) + 32'd1 == 32'(len);
    assign do_reload = reload && (state == S_DONE || state == S_ERROR);

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (do_reload),
        .strobe     (accept && state == S_DATA),
        .data       (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // loader FSM with registered handshake, memory-write and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LEN_LO;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= '0;
            wcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN_LO: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: if (accept) begin
                    len <= n_full;
                    if (32'(n_full) > DEPTH) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else if (n_full == '0) begin
                        state    <= S_END;
                        in_ready <= END_READY;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    acc <= acc ^ in_data;
`endif
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wcnt[ADDR_W-1:0];
                        imem_wdata <= word;
                        wcnt       <= wcnt + 1'b1;
                        if (last_word) begin
                            state    <= S_END;
                            in_ready <= END_READY;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: if (accept) begin
                    in_ready <= 1'b0;
                    state    <= (in_data == acc) ? S_FLUSH : S_ERROR;
                    error    <= (in_data != acc);
                end
`endif
                S_FLUSH: begin
                    state      <= S_DONE;
                    done       <= 1'b1;
                    core_reset <= 1'b0;
                end
                S_DONE, S_ERROR: if (reload) begin
                    state      <= S_LEN_LO;
                    in_ready   <= 1'b1;
                    core_reset <= 1'b1;
                    done       <= 1'b0;
                    error      <= 1'b0;
                    wcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
                    acc        <= '0;
`endif
                end
                default: begin
                    state    <= S_ERROR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule
